// File: rtl/bus_rr_scheduler_pkg.sv
// Shared types and helpers for the round-robin bus scheduler.
// Default widths plus the FSM state enum, a clog2 and a one-hot decoder.
package bus_rr_scheduler_pkg;

    localparam int N_REQ_DEF  = 4;
    localparam int DATA_W_DEF = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic logic [31:0] onehot(input int idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/bus_rr_scheduler_if.sv
// Requester-side and downstream-side signals of the scheduler, bundled as one port.
// master = requester FIFOs plus bus_control side; slave = the scheduler itself.
interface bus_rr_scheduler_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    out_ready;
    logic [DATA_W-1:0]       data_out;
    logic                    valid_out;
    logic [N_REQ-1:0]        control_out;
    logic                    err_stall;

    modport master (
        output req_valid, req_last, req_data, out_ready,
        input  req_ready, data_out, valid_out, control_out, err_stall
    );

    modport slave (
        input  req_valid, req_last, req_data, out_ready,
        output req_ready, data_out, valid_out, control_out, err_stall
    );
endinterface

// File: rtl/bus_rr_scheduler_rr_pick.sv
// Rotating-priority encoder: first requester after i_last (mod N_REQ) wins.
// Purely combinational, zero latency; no backpressure of its own.
module bus_rr_scheduler_rr_pick
    import bus_rr_scheduler_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        int w_cand;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = 0;
        // Walk from farthest to nearest so the nearest valid requester is written last.
        for (int k = N_REQ; k >= 1; k--) begin
            w_cand = (int'(i_last) + k) % N_REQ;
            if (i_req[w_cand]) begin
                o_idx = IDX_W'(w_cand);
                o_any = 1'b1;
            end
        end
        o_onehot = o_any ? N_REQ'(onehot(int'(o_idx))) : '0;
    end

endmodule

// File: rtl/bus_rr_scheduler.sv
// Round-robin packet scheduler feeding one registered word per cycle to bus_control.
// One cycle accept-to-data_out; req_ready of the granted requester follows !valid_out || out_ready.
module bus_rr_scheduler
    import bus_rr_scheduler_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 8,
    parameter int STALL_LIM = 15
) (
    input  logic              clk,
    input  logic              reset,
    bus_rr_scheduler_if.slave bus
);

    localparam int IDX_W = (N_REQ > 1) ? clog2(N_REQ) : 1;
    localparam int CNT_W = clog2(MAX_BURST) + 1;
    localparam int STL_W = clog2(STALL_LIM) + 1;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_grant, w_grant_nxt;
    logic [N_REQ-1:0]   r_ctrl, w_ctrl_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [STL_W-1:0]   r_stall, w_stall_nxt;
    logic               r_err, w_err_nxt;
    logic [DATA_W-1:0]  r_data;
    logic               r_valid;

    logic               w_slot, w_take, w_req_g, w_last_g, w_accept, w_any;
    logic [DATA_W-1:0]  w_word;
    logic [N_REQ-1:0]   w_pick_oh;
    logic [IDX_W-1:0]   w_pick_idx;

    bus_rr_scheduler_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .i_req    (bus.req_valid),
        .i_last   (r_grant),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_any    (w_any)
    );

    // The output register has room when empty or being drained this cycle.
    assign w_slot   = !r_valid || bus.out_ready;
    assign w_take   = r_valid && bus.out_ready;
    assign w_req_g  = bus.req_valid[r_grant];
    assign w_last_g = bus.req_last[r_grant];
    assign w_word   = bus.req_data[int'(r_grant)*DATA_W +: DATA_W];
    assign w_accept = (r_state == BURST) && w_req_g && w_slot;

    always_comb begin
        bus.req_ready = '0;
        if (r_state == BURST) bus.req_ready[r_grant] = w_slot;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ctrl_nxt  = r_ctrl;
        w_cnt_nxt   = r_cnt;
        w_stall_nxt = r_stall;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                w_ctrl_nxt = '0;
                if (w_any && w_slot) begin
                    w_state_nxt = BURST;
                    w_grant_nxt = w_pick_idx;
                    w_ctrl_nxt  = w_pick_oh;
                    w_cnt_nxt   = '0;
                    w_stall_nxt = '0;
                end
            end
            BURST: begin
                if (w_accept) begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_stall_nxt = '0;
                    if (w_last_g || r_cnt == CNT_W'(MAX_BURST - 1)) begin
                        w_state_nxt = IDLE;
                        w_ctrl_nxt  = '0;
                    end
                end else if (!w_req_g) begin
                    if (r_stall == STL_W'(STALL_LIM - 1)) begin
                        w_state_nxt = IDLE;
                        w_ctrl_nxt  = '0;
                        w_stall_nxt = '0;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_stall_nxt = r_stall + STL_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ctrl_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= IDX_W'(N_REQ - 1);
            r_ctrl  <= '0;
            r_cnt   <= '0;
            r_stall <= '0;
            r_err   <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ctrl  <= w_ctrl_nxt;
            r_cnt   <= w_cnt_nxt;
            r_stall <= w_stall_nxt;
            r_err   <= w_err_nxt;
            if (w_accept) begin
                r_data  <= w_word;
                r_valid <= 1'b1;
            end else if (w_take) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.data_out    = r_data;
    assign bus.valid_out   = r_valid;
    assign bus.control_out = r_ctrl;
    assign bus.err_stall   = r_err;

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Directed bench for bus_rr_scheduler: per-requester word lists feed the DUT, outputs checked each cycle.
module tb_bus_rr_scheduler;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_rr_scheduler_if #(.N_REQ(4), .DATA_W(16)) bus ();

    bus_rr_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    logic [15:0] src_w [4][16];
    logic        src_l [4][16];
    int          rd [4];
    int          wr [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [15:0] d, input logic [3:0] c);
        chk({tag, "_valid"}, {31'd0, bus.valid_out}, {31'd0, v});
        if (v) chk({tag, "_data"}, {16'd0, bus.data_out}, {16'd0, d});
        chk({tag, "_ctrl"}, {28'd0, bus.control_out}, {28'd0, c});
    endtask

    task automatic drive();
        logic [3:0]  v, l;
        logic [63:0] d;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < 4; i++) begin
            if (rd[i] < wr[i]) begin
                v[i] = 1'b1;
                l[i] = src_l[i][rd[i]];
                d[i*16 +: 16] = src_w[i][rd[i]];
            end
        end
        bus.req_valid = v;
        bus.req_last  = l;
        bus.req_data  = d;
    endtask

    task automatic push(input int r, input logic [15:0] w, input logic last);
        src_w[r][wr[r]] = w;
        src_l[r][wr[r]] = last;
        wr[r]++;
        drive();
    endtask

    // One clock: words offered and ready before the edge are retired from their lists.
    task automatic tick();
        logic [3:0] acc;
        acc = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (acc[i]) rd[i]++;
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin rd[i] = 0; wr[i] = 0; end
        bus.out_ready = 1'b1;
        drive();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk_out("rst", 1'b0, 16'h0, 4'b0000);
        chk("rst_data", {16'd0, bus.data_out}, 32'h0);
        chk("rst_err", {31'd0, bus.err_stall}, 32'd0);
        chk("rst_ready", {28'd0, bus.req_ready}, 32'd0);

        // Reset asserted mid-burst clears outputs without waiting for a clock
        push(1, 16'hFBA0, 1'b0); push(1, 16'hF0A1, 1'b0); push(1, 16'hF102, 1'b1);
        tick();
        tick();
        chk_out("midburst_pre", 1'b1, 16'hFBA0, 4'b0010);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", {31'd0, bus.valid_out}, 32'd0);
        chk("arst_data", {16'd0, bus.data_out}, 32'd0);
        chk("arst_ctrl", {28'd0, bus.control_out}, 32'd0);
        do_reset();

        // Round-robin over all four, one-word packets; req0 has a second packet
        push(0, 16'h1000, 1'b1); push(0, 16'h2000, 1'b1);
        push(1, 16'h1001, 1'b1); push(2, 16'h1002, 1'b1); push(3, 16'h1003, 1'b1);
        tick(); chk_out("rr_g0",  1'b0, 16'h0,    4'b0001);
        tick(); chk_out("rr_d0",  1'b1, 16'h1000, 4'b0000);
        tick(); chk_out("rr_g1",  1'b0, 16'h0,    4'b0010);
        tick(); chk_out("rr_d1",  1'b1, 16'h1001, 4'b0000);
        tick(); chk_out("rr_g2",  1'b0, 16'h0,    4'b0100);
        tick(); chk_out("rr_d2",  1'b1, 16'h1002, 4'b0000);
        tick(); chk_out("rr_g3",  1'b0, 16'h0,    4'b1000);
        tick(); chk_out("rr_d3",  1'b1, 16'h1003, 4'b0000);
        tick(); chk_out("rr_g0b", 1'b0, 16'h0,    4'b0001);
        tick(); chk_out("rr_d0b", 1'b1, 16'h2000, 4'b0000);

        // Single three-word packet from req1
        do_reset();
        push(1, 16'hFBA0, 1'b0); push(1, 16'hF0A1, 1'b0); push(1, 16'hF102, 1'b1);
        tick(); chk_out("pkt_grant", 1'b0, 16'h0,    4'b0010);
        tick(); chk_out("pkt_w0",    1'b1, 16'hFBA0, 4'b0010);
        tick(); chk_out("pkt_w1",    1'b1, 16'hF0A1, 4'b0010);
        tick(); chk_out("pkt_w2",    1'b1, 16'hF102, 4'b0000);
        tick(); chk_out("pkt_idle",  1'b0, 16'h0,    4'b0000);

        // Backpressure holds data_out and blocks the granted requester
        do_reset();
        push(2, 16'hA5D3, 1'b0); push(2, 16'hF1F0, 1'b1);
        tick(); chk_out("bp_grant", 1'b0, 16'h0, 4'b0100);
        tick(); chk_out("bp_w0", 1'b1, 16'hA5D3, 4'b0100);
        bus.out_ready = 1'b0;
        #1;
        chk("bp_ready_low", {28'd0, bus.req_ready}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_out("bp_hold", 1'b1, 16'hA5D3, 4'b0100);
            chk("bp_hold_ready", {28'd0, bus.req_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_ready_high", {28'd0, bus.req_ready}, 32'h4);
        tick(); chk_out("bp_w1", 1'b1, 16'hF1F0, 4'b0000);
        tick(); chk_out("bp_drain", 1'b0, 16'h0, 4'b0000);

        // Burst limit: ten words without last split into 8 + 2
        do_reset();
        for (int k = 0; k < 10; k++) push(2, 16'h5000 + 16'(k), 1'b0);
        tick(); chk_out("bl_grant", 1'b0, 16'h0, 4'b0100);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk_out("bl_word", 1'b1, 16'h5000 + 16'(k), (k == 7) ? 4'b0000 : 4'b0100);
        end
        tick(); chk_out("bl_regrant", 1'b0, 16'h0, 4'b0100);
        tick(); chk_out("bl_w8", 1'b1, 16'h5008, 4'b0100);
        tick(); chk_out("bl_w9", 1'b1, 16'h5009, 4'b0100);

        // Stall timeout: req3 goes quiet mid-burst, req0 waits behind it
        do_reset();
        push(3, 16'h3000, 1'b0);
        tick(); chk_out("st_grant", 1'b0, 16'h0, 4'b1000);
        push(0, 16'h0A0A, 1'b1);
        tick(); chk_out("st_w0", 1'b1, 16'h3000, 4'b1000);
        for (int e = 3; e <= 16; e++) begin
            tick();
            chk("st_hold_ctrl", {28'd0, bus.control_out}, 32'h8);
            chk("st_no_err", {31'd0, bus.err_stall}, 32'd0);
        end
        tick();
        chk("st_err_pulse", {31'd0, bus.err_stall}, 32'd1);
        chk("st_release", {28'd0, bus.control_out}, 32'd0);
        tick();
        chk("st_err_clear", {31'd0, bus.err_stall}, 32'd0);
        chk("st_next_grant", {28'd0, bus.control_out}, 32'h1);
        tick(); chk_out("st_next_word", 1'b1, 16'h0A0A, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
